// File: rtl/diffeq_seq_ctrl_if.sv
// Handshake bundle between the diffeq sequencing controller and its
// operand source / datapath. The controller uses the slave modport.
interface diffeq_seq_ctrl_if #(
   parameter int NUM_OPERANDS = 4,
   parameter int ITER_W       = 16,
   parameter int PHASE_W      = 4
);
   logic                    start;
   logic                    op_valid;
   logic [NUM_OPERANDS-1:0] op_sel;
   logic [NUM_OPERANDS-1:0] load_en;
   logic                    compute_done;
   logic                    continue_while;
   logic [ITER_W-1:0]       max_iter;
   logic [PHASE_W-1:0]      phase;
   logic                    phase_start;
   logic [ITER_W-1:0]       iter_count;
   logic [2:0]              state;
   logic                    busy;
   logic                    valid;
   logic                    result_ack;
   logic                    sel_err;
   logic                    iter_limit;
   logic                    timeout;

   modport master (
      output start, op_valid, op_sel, compute_done, continue_while, max_iter, result_ack,
      input  load_en, phase, phase_start, iter_count, state, busy, valid,
             sel_err, iter_limit, timeout
   );

   modport slave (
      input  start, op_valid, op_sel, compute_done, continue_while, max_iter, result_ack,
      output load_en, phase, phase_start, iter_count, state, busy, valid,
             sel_err, iter_limit, timeout
   );
endinterface

// File: rtl/diffeq_seq_ctrl.sv
// Sequencing controller for the differential-equation datapath: gathers
// operands via a one-hot select handshake, steps the datapath through the
// compute phases, loops on the datapath condition up to an iteration limit
// and holds the result valid until acknowledged.
// Optional watchdog on stalled phases: define DIFFEQ_CTRL_WATCHDOG_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// READ    | collecting operands until every operand has been loaded once
// COMPUTE | stepping phases 0..NUM_PHASES-1, advancing on compute_done
// CHECK   | one cycle: count the pass, decide loop-back or finish
// DONE    | result valid held until result_ack
module diffeq_seq_ctrl #(
   parameter int NUM_OPERANDS = 4,
   parameter int NUM_PHASES   = 4,
   parameter int ITER_W       = 16,
   parameter int PHASE_W      = 4,
   parameter int WDOG_CYCLES  = 1024
) (
   input logic               clk,
   input logic               reset_n,
   diffeq_seq_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      COMPUTE = 3'd2,
      CHECK   = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [NUM_OPERANDS-1:0] ALL_LOADED = '1;
   localparam logic [PHASE_W-1:0]      LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

   // Reject parameter sets the phase counter cannot represent
   if (NUM_PHASES < 1 || NUM_PHASES > (1 << PHASE_W)) begin : g_bad_phase_w
      $error("diffeq_seq_ctrl: PHASE_W too narrow for NUM_PHASES");
   end
   if (WDOG_CYCLES < 1) begin : g_bad_wdog
      $error("diffeq_seq_ctrl: WDOG_CYCLES must be at least 1");
   end

   state_t                  st;
   logic                    busy_q;
   logic                    valid_q;
   logic [NUM_OPERANDS-1:0] load_en_q;
   logic [NUM_OPERANDS-1:0] mask_q;
   logic [PHASE_W-1:0]      phase_q;
   logic                    phase_start_q;
   logic [ITER_W-1:0]       iter_q;
   logic [ITER_W-1:0]       max_q;
   logic                    sel_err_q;
   logic                    iter_limit_q;

   logic [NUM_OPERANDS-1:0] mask_next;
   logic                    sel_ok;
   logic [ITER_W:0]         iter_next;
   logic [ITER_W-1:0]       iter_sat;
   logic                    more_allowed;

   assign sel_ok       = $onehot(bus.op_sel);
   assign mask_next    = mask_q | bus.op_sel;
   // One extra bit so the limit compare never wraps at all-ones
   assign iter_next    = {1'b0, iter_q} + (ITER_W+1)'(1);
   assign iter_sat     = (&iter_q) ? iter_q : iter_next[ITER_W-1:0];
   assign more_allowed = (max_q == '0) || (iter_next < {1'b0, max_q});

`ifdef DIFFEQ_CTRL_WATCHDOG_EN
   localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);
   logic [WDOG_W-1:0] wdog_q;
   logic              timeout_q;
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   // Controller FSM; every output is a register updated here
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st            <= IDLE;
         busy_q        <= 1'b0;
         valid_q       <= 1'b0;
         load_en_q     <= '0;
         mask_q        <= '0;
         phase_q       <= '0;
         phase_start_q <= 1'b0;
         iter_q        <= '0;
         max_q         <= '0;
         sel_err_q     <= 1'b0;
         iter_limit_q  <= 1'b0;
`ifdef DIFFEQ_CTRL_WATCHDOG_EN
         wdog_q        <= '0;
         timeout_q     <= 1'b0;
`endif
      end else begin
         load_en_q     <= '0;
         phase_start_q <= 1'b0;
         case (st)
            IDLE: begin
               if (bus.start) begin
                  st           <= READ;
                  busy_q       <= 1'b1;
                  max_q        <= bus.max_iter;
                  iter_q       <= '0;
                  mask_q       <= '0;
                  sel_err_q    <= 1'b0;
                  iter_limit_q <= 1'b0;
`ifdef DIFFEQ_CTRL_WATCHDOG_EN
                  timeout_q    <= 1'b0;
`endif
               end
            end
            READ: begin
               if (bus.op_valid) begin
                  if (sel_ok) begin
                     load_en_q <= bus.op_sel;
                     mask_q    <= mask_next;
                     if (mask_next == ALL_LOADED) begin
                        st            <= COMPUTE;
                        phase_q       <= '0;
                        phase_start_q <= 1'b1;
`ifdef DIFFEQ_CTRL_WATCHDOG_EN
                        wdog_q        <= WDOG_LOAD;
`endif
                     end
                  end else begin
                     sel_err_q <= 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (bus.compute_done) begin
                  if (phase_q == LAST_PHASE) begin
                     st <= CHECK;
                  end else begin
                     phase_q       <= phase_q + PHASE_W'(1);
                     phase_start_q <= 1'b1;
`ifdef DIFFEQ_CTRL_WATCHDOG_EN
                     wdog_q        <= WDOG_LOAD;
`endif
                  end
               end
`ifdef DIFFEQ_CTRL_WATCHDOG_EN
               else if (wdog_q == '0) begin
                  st        <= DONE;
                  valid_q   <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  wdog_q <= wdog_q - WDOG_W'(1);
               end
`endif
            end
            CHECK: begin
               iter_q <= iter_sat;
               if (bus.continue_while && more_allowed) begin
                  st            <= COMPUTE;
                  phase_q       <= '0;
                  phase_start_q <= 1'b1;
`ifdef DIFFEQ_CTRL_WATCHDOG_EN
                  wdog_q        <= WDOG_LOAD;
`endif
               end else begin
                  st           <= DONE;
                  valid_q      <= 1'b1;
                  iter_limit_q <= bus.continue_while;
               end
            end
            DONE: begin
               if (bus.result_ack) begin
                  st      <= IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               st      <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state       = st;
   assign bus.busy        = busy_q;
   assign bus.valid       = valid_q;
   assign bus.load_en     = load_en_q;
   assign bus.phase       = phase_q;
   assign bus.phase_start = phase_start_q;
   assign bus.iter_count  = iter_q;
   assign bus.sel_err     = sel_err_q;
   assign bus.iter_limit  = iter_limit_q;

endmodule

// File: doc/diffeq_seq_ctrl.md
Name: diffeq_seq_ctrl

Overview:
Parametrised sequencing controller for the differential-equation datapath. It gathers NUM_OPERANDS operands through a one-hot select handshake, then steps the datapath through NUM_PHASES compute phases per iteration. It loops while the datapath requests another pass, up to a programmable iteration limit, and then holds a result-valid until it is acknowledged. It sits between the operand source/testbench and the datapath register file and ALU sequencer.

Parameters:
NUM_OPERANDS, 4, number of loadable operands (x, dx, u, a by default); range 1..8
NUM_PHASES, 4, compute phases per iteration; range 1..16
ITER_W, 16, width of the iteration counter and the max_iter input
PHASE_W, 4, width of the phase output; must satisfy 2**PHASE_W >= NUM_PHASES
WDOG_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
op_valid  in  1  operand select valid this cycle
op_sel  in  NUM_OPERANDS  one-hot operand select
load_en  out  NUM_OPERANDS  registered one-cycle load strobe to the operand registers
compute_done  in  1  datapath finished the current phase
continue_while  in  1  datapath loop condition, sampled in CHECK
max_iter  in  ITER_W  iteration limit; 0 = unlimited; sampled at start
phase  out  PHASE_W  current compute phase index
phase_start  out  1  one-cycle pulse on the first cycle of each phase
iter_count  out  ITER_W  completed iterations in the current run
state  out  3  encoded FSM state
busy  out  1  high in every state except IDLE
valid  out  1  result valid, high in DONE
result_ack  in  1  consumer accepts the result
sel_err  out  1  sticky flag: op_valid seen with a non-one-hot op_sel
iter_limit  out  1  run ended on max_iter while continue_while was still 1
timeout  out  1  watchdog abort flag; tied to 0 without the optional feature

Behaviour:
- Reset (reset_n=0 at a clk edge) has priority over all other inputs and is legal in any state, including mid-run. Effects: state=IDLE; all outputs 0; loaded mask, phase, iteration and watchdog counters cleared.
- State encoding: IDLE=0, READ=1, COMPUTE=2, CHECK=3, DONE=4. Values 5..7 are unreachable; if entered, the next state is IDLE.
- IDLE: start=1 -> READ. Latches max_iter, clears iter_count, sel_err, iter_limit and timeout.
- READ: each cycle with op_valid=1 and a one-hot op_sel:
  - load_en equals op_sel on the following cycle, for exactly one cycle.
  - The corresponding bit is set in the loaded mask.
  - Reloading an operand is legal; the datapath keeps the last value.
- READ: op_valid=1 with op_sel zero or multi-hot -> no strobe, mask unchanged, sel_err set (sticky until the next start).
- READ: when the mask is all ones, the next state is COMPUTE with phase=0. The final load_en and the entry into COMPUTE happen on the same cycle.
- COMPUTE: phase_start pulses on the first cycle of each phase, including after a loop-back.
  - compute_done=1 with phase<NUM_PHASES-1 -> phase+1 next cycle.
  - compute_done=1 with phase=NUM_PHASES-1 -> CHECK.
  - compute_done outside COMPUTE is ignored.
- CHECK: one cycle. iter_count increments by 1.
  - continue_while=1 and (max_iter=0 or iter_count+1<max_iter) -> COMPUTE, phase=0.
  - continue_while=1 and limit reached -> DONE, iter_limit=1.
  - continue_while=0 -> DONE.
- iter_count saturates at all ones when max_iter=0.
- DONE: valid=1 (registered; high from the first DONE cycle). result_ack=1 -> IDLE, with valid low on the next cycle. Outputs hold until ack.
- start while busy is ignored.
- Minimum run (1 operand, 1 phase, continue_while=0): start to valid takes 4 cycles plus the compute_done latency.

Optional Feature:
Macro DIFFEQ_CTRL_WATCHDOG_EN.
- Defined: a cycle counter is cleared at every phase_start and counts while in COMPUTE. If it reaches WDOG_CYCLES without compute_done, the FSM goes to DONE with timeout=1 (sticky until the next start), valid=1 and iter_count unchanged.
- Undefined: no counter is built, timeout is constant 0, and COMPUTE waits indefinitely.

Test Plan:
- Basic run: reset; start; op_sel 0001, 0010, 0100, 1000 on consecutive cycles; compute_done 2 cycles after each phase_start; continue_while=0 -> load_en mirrors op_sel one cycle later, phases 0..3, iter_count=1, valid=1 until result_ack, then state=0.
- Loop limit: max_iter=3, continue_while held at 1 -> three passes of 4 phases each, iter_count=3, iter_limit=1, valid=1.
- Bad select: in READ, op_sel=0110 with op_valid -> no load_en, mask unchanged, sel_err=1; the run still completes after four valid selects.
- Reload and out-of-order: op_sel 1000, 1000, 0001, 0100, 0010 -> COMPUTE entered only after the 5th select; load_en issued for every valid select.
- Reset mid-run: reset_n=0 for one cycle in COMPUTE phase 2 -> next cycle state=0, all outputs 0; a new start runs normally.
- Watchdog (macro defined, WDOG_CYCLES=8): no compute_done in phase 1 -> DONE after 8 cycles, timeout=1, valid=1. With the macro undefined, state stays at 2.
